// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: FSM states, the data-memory base
// address and the MEM/WB register field bundle.
package mem_stage_pkg;

  localparam logic [31:0] MEM_BASE_DEFAULT = 32'd1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu_result;
    logic [31:0] mem_read_value;
    logic [4:0]  dest;
    logic [31:0] pc;
  } memwb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads when the stage is not frozen, otherwise
// inserts a bubble by clearing the control bits while the data fields hold.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   bubble,
  input  memwb_t d,
  output memwb_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (bubble) begin
      q.wb_en    <= 1'b0;
      q.mem_r_en <= 1'b0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ready handshake,
// freezes upstream while an access is outstanding, and feeds write-back.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = MEM_BASE_DEFAULT,
  parameter int          ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_en_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       ST_val,
  input  logic [4:0]        Dest_in,
  input  logic [31:0]       PC_in,
  output logic              freeze,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              WB_en,
  output logic              MEM_R_EN,
  output logic [31:0]       ALU_result,
  output logic [31:0]       Mem_read_value,
  output logic [31:0]       PC,
  output logic [4:0]        Dest
);

  state_t      state, next_state;
  logic        mem_op;
  logic        issue;
  logic        capture;
  logic [31:0] read_buf;
  memwb_t      wb_d, wb_q;

  assign mem_op = MEM_R_EN_in | MEM_W_EN_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mem_op) next_state = ACCESS;
      ACCESS:  if (mem_ready) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    freeze  = 1'b0;
    issue   = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        freeze = mem_op;
        issue  = mem_op;
      end
      ACCESS: begin
        freeze  = 1'b1;
        capture = mem_ready;
      end
      default: ;
    endcase
  end

  // A load wins when both enables are set; the word address wraps to ADDR_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      read_buf  <= '0;
    end else if (issue) begin
      mem_req   <= 1'b1;
      mem_we    <= MEM_W_EN_in & ~MEM_R_EN_in;
      mem_addr  <= ADDR_W'((ALU_result_in - MEM_BASE) >> 2);
      mem_wdata <= ST_val;
    end else if (capture) begin
      mem_req <= 1'b0;
      if (!mem_we) read_buf <= mem_rdata;
    end
  end

  always_comb begin
    wb_d                = '0;
    wb_d.wb_en          = WB_en_in;
    wb_d.mem_r_en       = MEM_R_EN_in;
    wb_d.alu_result     = ALU_result_in;
    wb_d.mem_read_value = read_buf;
    wb_d.dest           = Dest_in;
    wb_d.pc             = PC_in;
  end

  mem_wb_reg u_mem_wb_reg (
    .clk    (clk),
    .rst    (rst),
    .bubble (freeze),
    .d      (wb_d),
    .q      (wb_q)
  );

  assign WB_en          = wb_q.wb_en;
  assign MEM_R_EN       = wb_q.mem_r_en;
  assign ALU_result     = wb_q.alu_result;
  assign Mem_read_value = wb_q.mem_read_value;
  assign Dest           = wb_q.dest;
  assign PC             = wb_q.pc;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected memory requests and
// write-back results; two monitors pop and compare when the DUT presents them.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
  logic [31:0] ALU_result_in, ST_val, PC_in;
  logic [4:0]  Dest_in;
  logic        freeze;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        WB_en, MEM_R_EN;
  logic [31:0] ALU_result, Mem_read_value, PC;
  logic [4:0]  Dest;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cycles;
  } mem_exp_t;

  typedef struct {
    logic [31:0] wb;
    logic [31:0] r;
    logic [31:0] alu;
    logic [31:0] val;
    logic        val_care;
    logic [31:0] dest;
    logic [31:0] pc;
  } wb_exp_t;

  mem_exp_t mem_q[$];
  wb_exp_t  wb_q[$];
  mem_exp_t mem_cur;
  wb_exp_t  wb_cur;
  bit       mem_active = 1'b0;
  int       mem_hold = 0;

  mem_stage #(.MEM_BASE(32'd1024), .ADDR_W(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .WB_en_in       (WB_en_in),
    .MEM_R_EN_in    (MEM_R_EN_in),
    .MEM_W_EN_in    (MEM_W_EN_in),
    .ALU_result_in  (ALU_result_in),
    .ST_val         (ST_val),
    .Dest_in        (Dest_in),
    .PC_in          (PC_in),
    .freeze         (freeze),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .WB_en          (WB_en),
    .MEM_R_EN       (MEM_R_EN),
    .ALU_result     (ALU_result),
    .Mem_read_value (Mem_read_value),
    .PC             (PC),
    .Dest           (Dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one instruction, play the memory side, and check freeze/bubbles.
  task automatic applyStimulus(input logic wb, input logic r, input logic w,
                               input logic [31:0] alu, input logic [31:0] st,
                               input logic [4:0] dest, input logic [31:0] pc,
                               input logic [15:0] exp_addr, input int delay,
                               input logic [31:0] rdata);
    logic is_mem;
    is_mem        = r | w;
    WB_en_in      = wb;
    MEM_R_EN_in   = r;
    MEM_W_EN_in   = w;
    ALU_result_in = alu;
    ST_val        = st;
    Dest_in       = dest;
    PC_in         = pc;
    if (is_mem)
      mem_q.push_back('{we: 32'(w & ~r), addr: 32'(exp_addr), wdata: st, cycles: delay + 1});
    if (wb | r)
      wb_q.push_back('{wb: 32'(wb), r: 32'(r), alu: alu, val: rdata, val_care: r,
                       dest: 32'(dest), pc: pc});
    @(negedge clk);
    checkOutput("freeze_issue", 32'(freeze), 32'(is_mem));
    if (is_mem) begin
      @(posedge clk); #1;
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        checkOutput("freeze_access", 32'(freeze), 32'd1);
        checkOutput("bubble_wb_en", 32'(WB_en), 32'd0);
        @(posedge clk); #1;
      end
      mem_ready = 1'b1;
      mem_rdata = rdata;
      @(negedge clk);
      checkOutput("freeze_ready", 32'(freeze), 32'd1);
      checkOutput("bubble_mem_r_en", 32'(MEM_R_EN), 32'd0);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      @(negedge clk);
      checkOutput("freeze_done", 32'(freeze), 32'd0);
      checkOutput("bubble_done", 32'(WB_en), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  // Memory-interface monitor: one expectation per request, held fields stable.
  always @(negedge clk) begin
    if (mem_req) begin
      if (!mem_active) begin
        if (mem_q.size() == 0) begin
          checkOutput("mem_unexpected_req", 32'd1, 32'd0);
        end else begin
          mem_cur    = mem_q.pop_front();
          mem_active = 1'b1;
          mem_hold   = 0;
        end
      end
      if (mem_active) begin
        mem_hold++;
        checkOutput("mem_we", 32'(mem_we), mem_cur.we);
        checkOutput("mem_addr", 32'(mem_addr), mem_cur.addr);
        checkOutput("mem_wdata", mem_wdata, mem_cur.wdata);
      end
    end else if (mem_active) begin
      checkOutput("mem_req_cycles", 32'(mem_hold), 32'(mem_cur.cycles));
      mem_active = 1'b0;
    end
  end

  // Write-back monitor: every non-bubble result presented pops one expectation.
  always @(negedge clk) begin
    if (!rst && (WB_en || MEM_R_EN)) begin
      if (wb_q.size() == 0) begin
        checkOutput("wb_unexpected", 32'd1, 32'd0);
      end else begin
        wb_cur = wb_q.pop_front();
        checkOutput("wb_en", 32'(WB_en), wb_cur.wb);
        checkOutput("wb_mem_r_en", 32'(MEM_R_EN), wb_cur.r);
        checkOutput("wb_alu_result", ALU_result, wb_cur.alu);
        checkOutput("wb_dest", 32'(Dest), wb_cur.dest);
        checkOutput("wb_pc", PC, wb_cur.pc);
        if (wb_cur.val_care)
          checkOutput("wb_mem_read_value", Mem_read_value, wb_cur.val);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    WB_en_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0;
    ALU_result_in = '0; ST_val = '0; Dest_in = '0; PC_in = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    #1;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_wb_en", 32'(WB_en), 32'd0);
    checkOutput("rst_alu_result", ALU_result, 32'd0);
    checkOutput("rst_freeze_nop", 32'(freeze), 32'd0);
    MEM_R_EN_in = 1'b1;
    #1;
    checkOutput("rst_freeze_from_inputs", 32'(freeze), 32'd1);
    MEM_R_EN_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors: wb, r, w, alu, st, dest, pc, expected word addr, ready delay, rdata
    applyStimulus(1, 0, 0, 32'h0000_1234, 32'h0,         5'd5,  32'h100, 16'h0000, 0, 32'h0);
    applyStimulus(1, 0, 0, 32'hFFFF_FFFF, 32'h0,         5'd31, 32'h104, 16'h0000, 0, 32'h0);
    applyStimulus(1, 1, 0, 32'd1032,      32'h0,         5'd7,  32'h108, 16'h0002, 0, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 1, 32'd1024,      32'hA5A5_A5A5, 5'd0,  32'h10C, 16'h0000, 4, 32'h1111_1111);
    checkOutput("read_buf_kept_on_store", dut.read_buf, 32'hDEAD_BEEF);
    applyStimulus(1, 1, 1, 32'd1040,      32'h5555_AAAA, 5'd12, 32'h110, 16'h0004, 1, 32'h0BAD_F00D);
    applyStimulus(1, 1, 0, 32'd1028,      32'h0,         5'd1,  32'h114, 16'h0001, 0, 32'hCAFE_0001);
    applyStimulus(1, 1, 0, 32'd1036,      32'h0,         5'd2,  32'h118, 16'h0003, 2, 32'hCAFE_0003);
    applyStimulus(1, 1, 0, 32'd1020,      32'h0,         5'd3,  32'h11C, 16'hFFFF, 0, 32'h7777_7777);
    applyStimulus(1, 1, 0, 32'h0004_0408, 32'h0,         5'd4,  32'h120, 16'h0002, 0, 32'h8888_8888);
    applyStimulus(1, 0, 0, 32'h0000_5A5A, 32'h0,         5'd6,  32'h1F0, 16'h0000, 0, 32'h0);

    // Load abandoned by an asynchronous reset while its request is outstanding.
    WB_en_in = 1; MEM_R_EN_in = 1; MEM_W_EN_in = 0;
    ALU_result_in = 32'd1044; ST_val = '0; Dest_in = 5'd9; PC_in = 32'h200;
    mem_q.push_back('{we: 32'd0, addr: 32'd5, wdata: 32'd0, cycles: 1});
    @(posedge clk); #1;
    @(negedge clk); #1;
    checkOutput("pre_rst_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    WB_en_in = 0; MEM_R_EN_in = 0; ALU_result_in = '0; Dest_in = '0; PC_in = '0;
    #1;
    checkOutput("arst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("arst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("arst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("arst_alu_result", ALU_result, 32'd0);
    checkOutput("arst_dest", 32'(Dest), 32'd0);
    checkOutput("arst_pc", PC, 32'd0);
    checkOutput("arst_mem_read_value", Mem_read_value, 32'd0);
    checkOutput("arst_freeze", 32'(freeze), 32'd0);
    checkOutput("arst_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    checkOutput("late_ready_mem_req", 32'(mem_req), 32'd0);
    checkOutput("late_ready_state", 32'(dut.state), 32'(IDLE));
    @(posedge clk); #1;
    checkOutput("late_ready_read_value", Mem_read_value, 32'd0);

    applyStimulus(1, 0, 0, 32'h0000_ABCD, 32'h0, 5'd4, 32'h300, 16'h0000, 0, 32'h0);
    applyStimulus(0, 0, 0, 32'h0,         32'h0, 5'd0, 32'h0,   16'h0000, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    checkOutput("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
